vec_seq_control: RTL and testbench

Multi-beat control sequencer for the vector processor. It accepts one vector instruction at a time over a valid/ready handshake, decodes the 3-bit opcode into register-file write enables and datapath mux selects, and replays those controls for ceil(vl/LANES) beats. On each beat it drives the element index, the memory address and the active-lane mask, and it stalls memory-class beats on `mem_ready`. It sits between instruction issue and the lane datapath/register files.

---
 rtl/vec_seq_control.sv | 166 ++++++++++++++++
 tb/tb_vec_seq_control.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_seq_control.sv
// vec_seq_control: multi-beat control sequencer for the vector lanes.
// Accepts one instruction at a time, decodes its opcode into write strobes
// and datapath selects, and replays them for ceil(vl/LANES) beats. Each beat
// drives the element index, beat address and active-lane mask. Memory-class
// beats stall on mem_ready.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE. op_code,
// base_addr and vl are sampled on that edge. instr_valid is ignored in every
// other state.
module vec_seq_control #(
    parameter int VLEN  = 16,
    parameter int LANES = 4,
    parameter int ADDRW = 8,
    parameter int VLW   = $clog2(VLEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       op_code,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [VLW-1:0]   vl,
    input  logic             mem_ready,
    output logic             we_a_reg,
    output logic             we_b_reg,
    output logic             we_mem,
    output logic             mux0,
    output logic             mux1,
    output logic             mux2,
    output logic [ADDRW-1:0] addr,
    output logic [VLW-1:0]   elem_idx,
    output logic [LANES-1:0] lane_mask,
    output logic             busy,
    output logic             done,
    output logic             illegal_op,
    output logic [1:0]       state_dbg
);

    localparam int LG_LANES = (LANES > 1) ? $clog2(LANES) : 0;
    // One extra bit so vl + LANES - 1 and the lane compares never overflow.
    localparam int CW = VLW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [ADDRW-1:0] base_q;
    logic [VLW-1:0]   vl_q;
    logic [VLW-1:0]   beat_q, beat_d;
    logic             load;

    logic [VLW-1:0]   vl_eff;
    logic             op_legal;
    logic [5:0]       dec;
    logic             mem_class;
    logic             go;
    logic [CW-1:0]    beats;
    logic             last_beat;
    logic [VLW-1:0]   elem_w;

    // Opcode table: {we_a, we_b, we_mem, mux0, mux1, mux2}.
    function automatic logic [5:0] decode(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b110: decode = 6'b100001;
            3'b100:                 decode = 6'b010010;
            3'b101:                 decode = 6'b001110;
            3'b111:                 decode = 6'b100000;
            default:                decode = 6'b000000;
        endcase
    endfunction

    assign state_dbg = state_q;
    assign op_legal  = (op_code[2:1] != 2'b01);
    assign vl_eff    = (vl > VLW'(VLEN)) ? VLW'(VLEN) : vl;
    assign dec       = decode(op_q);
    assign mem_class = (op_q[2:1] == 2'b10);
    assign go        = !mem_class || mem_ready;
    assign beats     = (CW'(vl_q) + CW'(LANES - 1)) >> LG_LANES;
    assign last_beat = (CW'(beat_q) == (beats - CW'(1)));
    assign elem_w    = beat_q << LG_LANES;

    // State, beat counter and instruction latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            op_q    <= '0;
            base_q  <= '0;
            vl_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (load) begin
                op_q   <= op_code;
                base_q <= base_addr;
                vl_q   <= vl_eff;
            end
        end
    end

    // Next state, beat advance and all outputs from registered state.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        load        = 1'b0;
        instr_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        illegal_op  = 1'b0;
        we_a_reg    = 1'b0;
        we_b_reg    = 1'b0;
        we_mem      = 1'b0;
        mux0        = 1'b0;
        mux1        = 1'b0;
        mux2        = 1'b0;
        addr        = '0;
        elem_idx    = '0;
        lane_mask   = '0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    if (op_legal) begin
                        load    = 1'b1;
                        beat_d  = '0;
                        state_d = (vl_eff == '0) ? S_DONE : S_EXEC;
                    end else begin
                        // Gated so every output except instr_ready is 0 in reset.
                        illegal_op = rst_n;
                    end
                end
            end
            S_EXEC: begin
                busy                   = 1'b1;
                {mux0, mux1, mux2}     = dec[2:0];
                {we_a_reg, we_b_reg, we_mem} = dec[5:3] & {3{go}};
                elem_idx               = elem_w;
                addr                   = base_q + ADDRW'(elem_w);
                // A lane is active while its element index is below vl.
                for (int i = 0; i < LANES; i++) begin
                    lane_mask[i] = (CW'(elem_w) + CW'(i)) < CW'(vl_q);
                end
                if (go) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + VLW'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_seq_control.sv
// Self-checking bench for vec_seq_control: table of instructions with their
// expected beat count and last-beat mask, a per-cycle expected-output queue
// compared on the falling edge, and hand-written reset / back-to-back cases.
module tb_vec_seq_control;

    localparam int VLEN  = 16;
    localparam int LANES = 4;
    localparam int ADDRW = 8;
    localparam int VLW   = 5;
    localparam int W     = 27;

    logic             clk;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       op_code;
    logic [ADDRW-1:0] base_addr;
    logic [VLW-1:0]   vl;
    logic             mem_ready;
    logic             we_a_reg, we_b_reg, we_mem;
    logic             mux0, mux1, mux2;
    logic [ADDRW-1:0] addr;
    logic [VLW-1:0]   elem_idx;
    logic [LANES-1:0] lane_mask;
    logic             busy, done, illegal_op;
    logic [1:0]       state_dbg;

    vec_seq_control #(
        .VLEN(VLEN), .LANES(LANES), .ADDRW(ADDRW), .VLW(VLW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .op_code(op_code), .base_addr(base_addr),
        .vl(vl), .mem_ready(mem_ready), .we_a_reg(we_a_reg),
        .we_b_reg(we_b_reg), .we_mem(we_mem), .mux0(mux0), .mux1(mux1),
        .mux2(mux2), .addr(addr), .elem_idx(elem_idx), .lane_mask(lane_mask),
        .busy(busy), .done(done), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] act_vec;
    logic [W-1:0] mon_exp;
    string        mon_tag;

    localparam logic [W-1:0] RST_VEC = {1'b1, 26'b0};

    assign act_vec = {instr_ready, busy, done, illegal_op,
                      we_a_reg, we_b_reg, we_mem, mux0, mux1, mux2,
                      addr, elem_idx, lane_mask};

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            check(mon_tag, act_vec, mon_exp);
        end
    end

    // ---------------- model helpers ----------------
    function automatic logic [5:0] tb_decode(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b110: return 6'b100001;
            3'b100:                 return 6'b010010;
            3'b101:                 return 6'b001110;
            3'b111:                 return 6'b100000;
            default:                return 6'b000000;
        endcase
    endfunction

    function automatic logic [W-1:0] mk(input logic rdy, input logic bsy,
                                        input logic dn, input logic ill,
                                        input logic [5:0] ctl,
                                        input logic [7:0] a,
                                        input logic [4:0] e,
                                        input logic [3:0] m);
        return {rdy, bsy, dn, ill, ctl, a, e, m};
    endfunction

    task automatic push(input string tag, input logic [W-1:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs presented while the sequencer is not in IDLE.
    logic             bg_valid = 1'b0;
    logic [2:0]       bg_op    = 3'b000;
    logic [ADDRW-1:0] bg_base  = '0;
    logic [VLW-1:0]   bg_vl    = '0;

    // ---------------- driver ----------------
    // Presents one instruction in IDLE and queues the expected output of every
    // cycle through to the done pulse. nb / last_m are the expected beat count
    // and last-beat lane mask for this instruction.
    task automatic run_instr(input string tag, input logic [2:0] op,
                             input logic [7:0] base, input logic [4:0] vlin,
                             input int stall_beat, input int stall_n,
                             input int nb, input logic [3:0] last_m);
        logic [5:0] d;
        logic       memop;
        logic       legal;
        logic [3:0] m;
        logic [7:0] a;
        int         ns;
        d     = tb_decode(op);
        memop = (op == 3'b100) || (op == 3'b101);
        legal = !((op == 3'b010) || (op == 3'b011));
        instr_valid = 1'b1;
        op_code     = op;
        base_addr   = base;
        vl          = vlin;
        mem_ready   = 1'($urandom_range(0, 1));
        push($sformatf("%s hs", tag), mk(1'b1, 1'b0, 1'b0, !legal, 6'b0, 8'h00, 5'd0, 4'h0));
        step();
        if (bg_valid) begin
            instr_valid = 1'b1;
            op_code     = bg_op;
            base_addr   = bg_base;
            vl          = bg_vl;
        end else begin
            instr_valid = 1'b0;
            op_code     = 3'($urandom_range(0, 7));
            base_addr   = 8'($urandom_range(0, 255));
            vl          = 5'($urandom_range(0, 31));
        end
        if (!legal) return;
        for (int b = 0; b < nb; b++) begin
            a  = base + 8'(b * LANES);
            m  = (b == nb - 1) ? last_m : 4'hF;
            ns = (memop && b == stall_beat) ? stall_n : 0;
            for (int s = 0; s < ns; s++) begin
                mem_ready = 1'b0;
                push($sformatf("%s b%0d stall%0d", tag, b, s),
                     mk(1'b0, 1'b1, 1'b0, 1'b0, {3'b000, d[2:0]}, a, 5'(b * LANES), m));
                step();
            end
            mem_ready = memop ? 1'b1 : 1'($urandom_range(0, 1));
            push($sformatf("%s b%0d", tag, b),
                 mk(1'b0, 1'b1, 1'b0, 1'b0, d, a, 5'(b * LANES), m));
            step();
        end
        mem_ready = 1'($urandom_range(0, 1));
        push($sformatf("%s done", tag), mk(1'b0, 1'b0, 1'b1, 1'b0, 6'b0, 8'h00, 5'd0, 4'h0));
        step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      tag;
        logic [2:0] op;
        logic [7:0] base;
        logic [4:0] vl;
        int         stall_beat;
        int         stall_n;
        int         exp_beats;
        logic [3:0] exp_last_mask;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int         vle;
        int         nb;
        logic [3:0] lm;

        tbl[0]  = '{"op000_vl16",   3'b000, 8'h10, 5'd16, -1, 0, 4, 4'hF};
        tbl[1]  = '{"op101_stall",  3'b101, 8'h20, 5'd6,   1, 2, 2, 4'h3};
        tbl[2]  = '{"ill_010",      3'b010, 8'h00, 5'd5,  -1, 0, 0, 4'h0};
        tbl[3]  = '{"op100_vl0",    3'b100, 8'h40, 5'd0,  -1, 0, 0, 4'h0};
        tbl[4]  = '{"op111_wrap",   3'b111, 8'hFC, 5'd8,  -1, 0, 2, 4'hF};
        tbl[5]  = '{"op111_clamp",  3'b111, 8'h30, 5'd20, -1, 0, 4, 4'hF};
        tbl[6]  = '{"op001_vl4",    3'b001, 8'h00, 5'd4,  -1, 0, 1, 4'hF};
        tbl[7]  = '{"op110_vl5",    3'b110, 8'h80, 5'd5,  -1, 0, 2, 4'h1};
        tbl[8]  = '{"op100_stall0", 3'b100, 8'h50, 5'd9,   0, 3, 3, 4'h1};
        tbl[9]  = '{"ill_011",      3'b011, 8'h11, 5'd3,  -1, 0, 0, 4'h0};
        tbl[10] = '{"op000_vl1",    3'b000, 8'h08, 5'd1,  -1, 0, 1, 4'h1};
        tbl[11] = '{"op101_vl3",    3'b101, 8'hF0, 5'd3,   0, 1, 1, 4'h7};
        tbl[12] = '{"op100_vl31",   3'b100, 8'hFE, 5'd31,  3, 1, 4, 4'hF};

        // ---- reset ----
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        op_code     = 3'b000;
        base_addr   = '0;
        vl          = '0;
        mem_ready   = 1'b0;
        #2;
        check("reset_state", act_vec, RST_VEC);
        instr_valid = 1'b1;
        op_code     = 3'b010;
        #1;
        check("reset_illegal_gated", act_vec, RST_VEC);
        instr_valid = 1'b0;
        op_code     = 3'b000;
        step();
        step();
        rst_n = 1'b1;
        step();

        // ---- table ----
        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].tag, tbl[i].op, tbl[i].base, tbl[i].vl,
                      tbl[i].stall_beat, tbl[i].stall_n,
                      tbl[i].exp_beats, tbl[i].exp_last_mask);
        end

        // ---- back-to-back: second op held valid through EXEC/DONE ----
        bg_valid = 1'b1;
        bg_op    = 3'b100;
        bg_base  = 8'h60;
        bg_vl    = 5'd4;
        run_instr("b2b_first", 3'b000, 8'h00, 5'd8, -1, 0, 2, 4'hF);
        bg_valid = 1'b0;
        run_instr("b2b_second", 3'b100, 8'h60, 5'd4, 0, 1, 1, 4'hF);

        // ---- illegal opcode held while busy must not pulse illegal_op ----
        bg_valid = 1'b1;
        bg_op    = 3'b011;
        bg_base  = 8'h00;
        bg_vl    = 5'd2;
        run_instr("hold_ill", 3'b110, 8'h70, 5'd7, -1, 0, 2, 4'h7);
        bg_valid = 1'b0;
        run_instr("ill_after_hold", 3'b011, 8'h00, 5'd2, -1, 0, 0, 4'h0);

        // ---- random instructions ----
        for (int r = 0; r < 16; r++) begin
            logic [2:0] rop;
            logic [7:0] rbase;
            logic [4:0] rvl;
            rop   = 3'($urandom_range(0, 7));
            rbase = 8'($urandom_range(0, 255));
            rvl   = 5'($urandom_range(0, 20));
            vle   = (rvl > VLEN) ? VLEN : int'(rvl);
            nb    = (vle + LANES - 1) / LANES;
            lm    = ((vle % LANES) == 0) ? 4'hF : 4'((1 << (vle % LANES)) - 1);
            if (rop == 3'b010 || rop == 3'b011) nb = 0;
            run_instr($sformatf("rand%0d_op%0d", r, rop), rop, rbase, rvl,
                      $urandom_range(0, 4), $urandom_range(0, 3), nb, lm);
        end

        // ---- reset in the middle of EXEC ----
        instr_valid = 1'b1;
        op_code     = 3'b000;
        base_addr   = 8'h10;
        vl          = 5'd16;
        mem_ready   = 1'b1;
        push("rstmid hs", mk(1'b1, 1'b0, 1'b0, 1'b0, 6'b0, 8'h00, 5'd0, 4'h0));
        step();
        instr_valid = 1'b0;
        push("rstmid b0", mk(1'b0, 1'b1, 1'b0, 1'b0, 6'b100001, 8'h10, 5'd0, 4'hF));
        step();
        rst_n = 1'b0;
        #1;
        check("rstmid_immediate", act_vec, RST_VEC);
        step();
        check("rstmid_held", act_vec, RST_VEC);
        rst_n = 1'b1;
        run_instr("post_rst_op001", 3'b001, 8'h33, 5'd4, -1, 0, 1, 4'hF);

        // ---- wrap up ----
        instr_valid = 1'b0;
        step();
        step();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
